// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 op codes,
// FSM state type and the most-negative-value helper.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    // Most-negative two's complement value for a w-bit word (w <= 64).
    function automatic logic [63:0] min_neg(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One combinational restoring-division step on {rem, quot}.
module muldiv_divstep #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Shift {rem,quot} left, trial-subtract, restore on a negative result.
    always_comb begin
        shifted   = {rem, quot[WIDTH-1]};
        fits      = shifted >= {1'b0, divisor};
        // When the subtraction is kept the true difference is below the
        // divisor, so the low WIDTH bits are exact.
        diff      = shifted[WIDTH-1:0] - divisor;
        rem_next  = fits ? diff : shifted[WIDTH-1:0];
        quot_next = {quot[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and multiply
// by zero skip the iterations and go straight to DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int unsigned      CNT_W  = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MinNeg = WIDTH'(min_neg(WIDTH));

    state_e               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 dz_q, dz_d;
    logic                 ovf_q, ovf_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 out_valid_q, out_valid_d;

    logic                 is_div, sa, sb, neg_in, dz_in, ovf_in;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next, acc_step, prod_fix;
    logic [WIDTH-1:0]     rem_next, quot_next, quot_fix, rem_fix, final_res;
`ifdef MULDIV_EARLY_OUT_EN
    logic                 mz_in;
`endif

    // Results that bypass the datapath: multiply by zero, divide by zero, overflow.
    function automatic logic [WIDTH-1:0] special_res(input logic [2:0] f,
                                                     input logic [WIDTH-1:0] dividend,
                                                     input logic dz);
        if (!f[2]) return '0;
        if (!f[1]) return dz ? '1 : MinNeg;
        return dz ? dividend : '0;
    endfunction

    // Operand decode: signedness, magnitudes, result sign and special cases.
    always_comb begin
        is_div = op[2];
        sa     = ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM))
                 && a[WIDTH-1];
        sb     = ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM)) && b[WIDTH-1];
        mag_a  = sa ? -a : a;
        mag_b  = sb ? -b : b;
        neg_in = (op == OP_REM) ? sa : (sa ^ sb);
        dz_in  = is_div && (b == '0);
        ovf_in = ((op == OP_DIV) || (op == OP_REM)) && (a == MinNeg) && (b == '1);
`ifdef MULDIV_EARLY_OUT_EN
        mz_in  = !is_div && ((a == '0) || (b == '0));
`endif
    end

    muldiv_divstep #(
        .WIDTH (WIDTH)
    ) u_divstep (
        .rem       (acc_q[2*WIDTH-1:WIDTH]),
        .quot      (acc_q[WIDTH-1:0]),
        .divisor   (mcand_q),
        .rem_next  (rem_next),
        .quot_next (quot_next)
    );

    // One iteration: shift-add multiply or restoring divide, then sign fix-up.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        acc_step = op_q[2] ? {rem_next, quot_next} : mul_next;
        prod_fix = neg_q ? -acc_step : acc_step;
        quot_fix = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        rem_fix  = neg_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:                       final_res = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              final_res = quot_fix;
            default:                      final_res = rem_fix;
        endcase
        if (dz_q || ovf_q) begin
            final_res = special_res(op_q, a_q, dz_q);
        end
    end

    // Next-state logic for the IDLE/BUSY/DONE controller and datapath registers.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        a_d         = a_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d    = op;
                    a_d     = a;
                    acc_d   = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                    mcand_d = is_div ? mag_b : mag_a;
                    neg_d   = neg_in;
                    dz_d    = dz_in;
                    ovf_d   = ovf_in;
                    cnt_d   = CNT_W'(WIDTH);
`ifdef MULDIV_EARLY_OUT_EN
                    if (dz_in || ovf_in || mz_in) begin
                        result_d    = special_res(op, a, dz_in);
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        state_d = StBusy;
                    end
`else
                    state_d = StBusy;
`endif
                end
            end
            StBusy: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d    = final_res;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= OP_MUL;
            acc_q       <= '0;
            mcand_q     <= '0;
            a_q         <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            a_q         <= a_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32) with a result scoreboard.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        in_ready, out_valid, busy;
    logic [31:0] result;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    muldiv_unit #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model using native 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint      sx, sy, p;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin u = {32'd0, x} * {32'd0, y}; return u[31:0]; end
            3'd1: begin p = sx * sy; u = p; return u[63:32]; end
            3'd2: begin p = sx * longint'({32'd0, y}); u = p; return u[63:32]; end
            3'd3: begin u = {32'd0, x} * {32'd0, y}; return u[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sx / sy; u = p; return u[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                p = sx % sy; u = p; return u[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x,
                                   input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
        if (o[2] && y == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        if (!o[2] && (x == 0 || y == 0)) return 1;
`endif
        return 33;
    endfunction

    // Issue one op, wait for its result, optionally stall hold cycles, then drain.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int hold);
        int          lat;
        logic [31:0] e;
        int          el;
        logic [31:0] first;
        @(negedge clk);
        check("in_ready before issue", in_ready, 1);
        op = o; a = x; b = y; in_valid = 1'b1;
        exp_q.push_back(model(o, x, y));
        lat_q.push_back(exp_lat(o, x, y));
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 100);
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        if (!out_valid) begin
            check("out_valid timeout", 0, 1);
        end else begin
            check($sformatf("result op%0d %h %h", o, x, y), result, e);
            check($sformatf("latency op%0d", o), lat, el);
            check("in_ready low in DONE", in_ready, 0);
            first = result;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("stall result stable", result, first);
                check("stall in_ready low", in_ready, 0);
                check("stall out_valid high", out_valid, 1);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("out_valid after drain", out_valid, 0);
            check("in_ready after drain", in_ready, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset result", result, 0);
        check("reset busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);
        check("in_ready after reset", in_ready, 1);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        check("MUL 7*-3 model", model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'd100, 32'd7, 0);
        run_op(3'd7, 32'd100, 32'd7, 10);
        run_op(3'd4, 32'd5, 32'd0, 0);
        run_op(3'd7, 32'd5, 32'd0, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd0, 32'd0, 32'h1234_5678, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        for (int i = 0; i < 16; i++) begin
            run_op(3'($urandom_range(0, 7)), $urandom,
                   (i % 2) ? 32'($urandom_range(1, 300)) : $urandom, 0);
        end

        // Flush at the fifth BUSY cycle discards the operation.
        @(negedge clk);
        op = 3'd5; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("busy before flush", busy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", busy, 0);
        check("flush out_valid", out_valid, 0);
        check("flush in_ready", in_ready, 1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no out_valid after flush", seen, 0);

        // Reset in the middle of BUSY.
        @(negedge clk);
        op = 3'd0; a = 32'd3; b = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid reset out_valid", out_valid, 0);
        check("mid reset result", result, 0);
        check("mid reset busy", busy, 0);
        check("mid reset in_ready", in_ready, 1);
        run_op(3'd5, 32'd9, 32'd3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
